// File: rtl/ocp_slave_arbiter_pkg.sv
// Shared OCP encodings and types for the slave arbiter.
// The command/response codes mirror the common OCP constant header.
package ocp_slave_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = 4;

    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;

    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
    localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
    localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

    typedef logic [7:0] tmo_cnt_t;

    typedef struct packed {
        logic [2:0]            cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BEN_WIDTH-1:0]  ben;
    } ocp_req_t;

endpackage

// File: rtl/ocp_slave_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1,
// wrapping, returned as a one-hot grant plus a valid flag.
module rr_pick #(
    parameter int N  = 2,
    parameter int LW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!vld && req[k] && (k == (int'(last) + i) % N)) begin
                    gnt[k] = 1'b1;
                    vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ocp_slave_arbiter.sv
// Round-robin sharing of one OCP slave between NMASTERS masters, one
// outstanding transaction at a time, with a response timeout.
module ocp_slave_arbiter
    import ocp_slave_arbiter_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NMASTERS-1:0][ADDR_WIDTH-1:0]  i_MAddr,
    input  logic [NMASTERS-1:0][2:0]             i_MCmd,
    input  logic [NMASTERS-1:0][DATA_WIDTH-1:0]  i_MData,
    input  logic [NMASTERS-1:0][BEN_WIDTH-1:0]   i_MByteEn,
    output logic [NMASTERS-1:0]                  o_SCmdAccept,
    output logic [NMASTERS-1:0][DATA_WIDTH-1:0]  o_SData,
    output logic [NMASTERS-1:0][1:0]             o_SResp,
    output logic [ADDR_WIDTH-1:0]                o_MAddr,
    output logic [2:0]                           o_MCmd,
    output logic [DATA_WIDTH-1:0]                o_MData,
    output logic [BEN_WIDTH-1:0]                 o_MByteEn,
    input  logic                                 i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0]                i_SData,
    input  logic [1:0]                           i_SResp,
    output logic [NMASTERS-1:0]                  o_gnt
);

    localparam int LW = $clog2(NMASTERS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]          state, state_nxt;
    logic [NMASTERS-1:0] req, pick_gnt;
    logic                pick_vld;
    logic [LW-1:0]       pick_idx, own, last;
    tmo_cnt_t            cnt;
    ocp_req_t            mreq;
    logic                resp_vld, acc, fwd, tmo;

    for (genvar k = 0; k < NMASTERS; k++) begin : g_req
        assign req[k] = (i_MCmd[k] != OCP_CMD_IDLE);
    end

    rr_pick #(.N(NMASTERS), .LW(LW)) u_pick (
        .req  (req),
        .last (last),
        .gnt  (pick_gnt),
        .vld  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NMASTERS; k++)
            if (pick_gnt[k]) pick_idx = LW'(k);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_CMD;
            ST_CMD:  if (acc) state_nxt = resp_vld ? ST_IDLE : ST_RESP;
            ST_RESP: if (resp_vld || tmo) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The counter only ever sits at 1 in the final wait cycle, so ERR lands
    // exactly TIMEOUT cycles after the accept cycle.
    always_comb begin
        resp_vld = (i_SResp != OCP_RESP_NULL);
        acc      = (state == ST_CMD) && i_SCmdAccept;
        fwd      = resp_vld && (acc || (state == ST_RESP));
        tmo      = (state == ST_RESP) && !resp_vld && (cnt <= 8'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mreq  <= '0;
            o_gnt <= '0;
            own   <= '0;
            last  <= LW'(NMASTERS - 1);
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (pick_vld) begin
                    mreq  <= '{cmd:  i_MCmd[pick_idx],    addr: i_MAddr[pick_idx],
                               data: i_MData[pick_idx],   ben:  i_MByteEn[pick_idx]};
                    o_gnt <= pick_gnt;
                    own   <= pick_idx;
                end
                ST_CMD: if (i_SCmdAccept) begin
                    mreq.cmd <= OCP_CMD_IDLE;
                    cnt      <= tmo_cnt_t'(TIMEOUT);
                    if (resp_vld) begin
                        last  <= own;
                        o_gnt <= '0;
                    end
                end
                ST_RESP: begin
                    if (cnt != '0) cnt <= cnt - 8'd1;
                    if (resp_vld || tmo) begin
                        last  <= own;
                        o_gnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_MAddr   = mreq.addr;
    assign o_MCmd    = mreq.cmd;
    assign o_MData   = mreq.data;
    assign o_MByteEn = mreq.ben;

    // Reset forces every master-facing response quiet, dropping late slave replies.
    for (genvar k = 0; k < NMASTERS; k++) begin : g_route
        logic sel;
        assign sel             = !rst && o_gnt[k];
        assign o_SCmdAccept[k] = sel && acc;
        assign o_SResp[k]      = !sel ? OCP_RESP_NULL :
                                 fwd  ? i_SResp       :
                                 tmo  ? OCP_RESP_ERR  : OCP_RESP_NULL;
        assign o_SData[k]      = (sel && fwd) ? i_SData : '0;
    end

endmodule

// File: doc/ocp_slave_arbiter.md
# ocp_slave_arbiter

Round-robin arbiter that shares one OCP slave, such as `interval_timer`, between `NMASTERS` OCP masters, for example the CPU core and a debug/DMA port. It serialises commands so that only one transaction is outstanding at the slave at a time. It routes the slave's response back to the owning master only. A response timeout keeps a non-answering slave from locking the bus.

## Interface
Parameters:
- `NMASTERS`, default 2: number of requesting masters, 2..4.
- `TIMEOUT`, default 16: maximum cycles spent waiting for `SResp` after accept; 1..255.

Ports (`N` = `NMASTERS`; per-master buses are flattened, with master *k* at slice *k*):
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `i_MAddr`  in  N*`ADDR_WIDTH`: master addresses.
- `i_MCmd`  in  N*3: master commands (`OCP_CMD_*`).
- `i_MData`  in  N*`DATA_WIDTH`: master write data.
- `i_MByteEn`  in  N*`BEN_WIDTH`: master byte enables.
- `o_SCmdAccept`  out  N: per-master command accept.
- `o_SData`  out  N*`DATA_WIDTH`: per-master read data.
- `o_SResp`  out  N*2: per-master response.
- `o_MAddr`, `o_MCmd`, `o_MData`, `o_MByteEn`  out: slave-side command, all registered.
- `i_SCmdAccept`, `i_SData`, `i_SResp`  in: slave-side accept and response.
- `o_gnt`  out  N: one-hot current owner, for debug.

## Operation
- **FSM states:** IDLE, CMD, RESP.
- **IDLE:**
  - The requester set is every *k* with `i_MCmd[k] != OCP_CMD_IDLE`.
  - The winner is the first requester found searching from `(last+1) mod N` upward with wrap.
  - The winner's command fields are registered onto `o_M*`, `o_gnt` is set to the winner, and the FSM goes to CMD.
- **CMD:**
  - `o_M*` is held stable.
  - On `i_SCmdAccept=1`, pulse `o_SCmdAccept[owner]` in the same cycle (combinational pass-through), register `o_MCmd <= IDLE`, load the timeout counter with `TIMEOUT`, and go to RESP.
  - If `i_SResp != NULL` arrives in the same cycle as accept, the response is forwarded in that cycle, and the FSM goes directly to IDLE.
- **RESP:**
  - The counter decrements each cycle.
  - On `i_SResp != NULL`, forward `i_SResp`/`i_SData` to `o_SResp[owner]`/`o_SData[owner]` for that cycle, set `last <= owner`, clear `o_gnt`, and go to IDLE.
  - When the counter reaches 0 without a response, drive `o_SResp[owner] = OCP_RESP_ERR` with `o_SData = 0` for one cycle, set `last <= owner`, and go to IDLE.
- **Routing:** non-owners always see `o_SCmdAccept=0`, `o_SResp=NULL` and `o_SData=0`.
- **Master obligations:** a master holds its command until it sees its accept. A master dropping its request while in CMD is a protocol violation; the arbiter ignores it and completes the transaction.
- **Reset:**
  - Reset takes precedence mid-transaction: it returns to IDLE and drops any outstanding response.
  - Reset values: all outputs 0, so `o_MCmd = IDLE`, `o_SResp = NULL` and `o_gnt = 0`; `last = N-1`, so master 0 wins first.

## Timing
- **Latency:** a request seen in IDLE at edge *n* appears on `o_M*` after edge *n*. The earliest slave accept is cycle *n+1*. The minimum turnaround from request to response is 2 cycles when the slave accepts and responds in the same cycle, and 3 cycles when the response comes one cycle after accept.
- **Back-to-back:** one idle cycle follows every completion, because arbitration happens in IDLE. Sustained throughput is therefore one transaction per 3 cycles with a 1-cycle slave.
- **Fairness:** under continuous requests from all masters, grants rotate strictly 0,1,…,N-1,0. No master waits more than N-1 transactions.
- **Timeout:** ERR is returned exactly `TIMEOUT` cycles after the accept cycle. A response arriving in that same final cycle wins over ERR.
- **Counter width:** 8 bits, no wrap; the counter saturates at 0.

## Structure
- `OCP_CMD_*`, `OCP_RESP_*` and the width macros come from the shared `ocp_const.vh` / `common.vh`; no new shared constants.
- FSM state encoding is local parameters inside the block.
- One sub-module is natural: `rr_pick`, a combinational N-way round-robin priority picker taking the request vector and `last` and returning a one-hot grant plus a valid flag.

## Test plan
1. **Reset:** hold `rst=1` for 3 cycles with both masters requesting → all outputs 0 during reset. Master 0 is granted first after reset.
2. **Single read:** M1 reads 0x008 with the slave responding DVA, data 0x0000000C, one cycle after accept → only M1 sees the accept and the DVA/0xC. M0's outputs stay 0.
3. **Contention:** M0 and M1 issue continuous writes of 0x10 to 0x004 → grants alternate 0,1,0,1. Each master gets exactly one accept per 6 cycles.
4. **Same-cycle accept and response:** the slave asserts accept together with DVA → the FSM goes CMD→IDLE with no RESP cycle, and the next grant is issued 1 cycle later.
5. **Timeout:** `TIMEOUT=4` with a slave that accepts and never responds → the owner sees ERR and data 0 exactly 4 cycles after accept, after which the other master is granted.
6. **Reset mid-RESP:** assert `rst` while in RESP → on the next edge the FSM is in IDLE with `o_gnt=0`, and a late slave `DVA` is not forwarded to any master.
